// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the two-port round-robin arbiter in front of
// the single-port 256x8 data memory.
package data_mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of both requester ports plus the memory-side controls; the arbiter
// uses the slave view, requesters and the memory model use the master view.
interface data_mem_arbiter_if
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);
  // Handshake: reqN is sampled only while the arbiter is IDLE; once granted,
  // the burst runs to completion with one ackN pulse per beat and doneN on
  // the last one. Write data for beat k+1 must be presented after ack of beat k.
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [LEN_W-1:0]  len0, len1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic              done0, done1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              busy;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_out;
  state_t            dbg_state;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
    input  mem_out,
    output ack0, ack1, done0, done1, rdata0, rdata1, busy,
    output mem_write, mem_read, mem_addr, mem_data, dbg_state
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
    output mem_out,
    input  ack0, ack1, done0, done1, rdata0, rdata1, busy,
    input  mem_write, mem_read, mem_addr, mem_data, dbg_state
  );

endinterface

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// port that did not win last.
module mem_rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_last,
  output logic o_gnt_valid,
  output logic o_gnt_idx
);

  always_comb begin
    o_gnt_valid = i_req0 | i_req1;
    o_gnt_idx   = 1'b0;
    if (i_req0 && i_req1) begin
      o_gnt_idx = ~i_rr_last;
    end else if (i_req1) begin
      o_gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Burst arbiter for the shared data memory: grants one port per burst and
// sequences ISSUE/ACK pairs, two cycles per beat.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
)(
  input  logic           clock,
  input  logic           reset_n,
  data_mem_arbiter_if.slave bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_rr_last;
  logic              r_grant;
  logic              r_cur_we;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_gnt_valid;
  logic              w_gnt_idx;
  logic              w_in_issue;
  logic              w_in_ack;
  logic              w_last_beat;

  mem_rr_pick2 u_pick (
    .i_req0      (bus.req0),
    .i_req1      (bus.req1),
    .i_rr_last   (r_rr_last),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  assign w_in_issue  = (r_state == ISSUE);
  assign w_in_ack    = (r_state == ACK);
  assign w_last_beat = (r_cnt == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_next_state = ISSUE;
      ISSUE:   w_next_state = ACK;
      ACK:     w_next_state = w_last_beat ? IDLE : ISSUE;
      default: w_next_state = IDLE;
    endcase
  end

  // Burst context is captured only on the IDLE->ISSUE grant, so requesters
  // may change or drop their request fields once the burst has started.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_last  <= PORT_DMA;
      r_grant    <= PORT_CPU;
      r_cur_we   <= 1'b0;
      r_cur_addr <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_grant    <= w_gnt_idx;
            r_cur_we   <= w_gnt_idx ? bus.we1   : bus.we0;
            r_cur_addr <= w_gnt_idx ? bus.addr1 : bus.addr0;
            r_cnt      <= w_gnt_idx ? bus.len1  : bus.len0;
          end
        end
        ACK: begin
          if (w_last_beat) begin
            r_rr_last <= r_grant;
          end else begin
            r_cnt      <= r_cnt - LEN_W'(1);
            r_cur_addr <= r_cur_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Read data is captured from the combinational memory output at the end
  // of ISSUE, so it is valid with the ack and held until the next read beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_in_issue && !r_cur_we) begin
      if (r_grant == PORT_DMA) begin
        r_rdata1 <= bus.mem_out;
      end else begin
        r_rdata0 <= bus.mem_out;
      end
    end
  end

  assign bus.mem_write = w_in_issue && r_cur_we;
  assign bus.mem_read  = w_in_issue && !r_cur_we;
  assign bus.mem_addr  = r_cur_addr;
  assign bus.mem_data  = (r_grant == PORT_DMA) ? bus.wdata1 : bus.wdata0;

  assign bus.ack0  = w_in_ack && (r_grant == PORT_CPU);
  assign bus.ack1  = w_in_ack && (r_grant == PORT_DMA);
  assign bus.done0 = bus.ack0 && w_last_beat;
  assign bus.done1 = bus.ack1 && w_last_beat;

  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.busy      = (r_state != IDLE);
  assign bus.dbg_state = r_state;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port 256x8 `dataMemory` between two requesters: port 0 is the CPU load/store stage, port 1 is the block-copy/DMA engine.
- Requesters issue bursts of 1..16 beats with an auto-incrementing address.
- The block round-robin arbitrates between bursts and sequences the `memWrite`/`memRead`/`address`/`data` controls.
- It registers the memory's read data and returns it with a per-beat ack.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- LEN_W, 4, burst length field width; burst beats = len+1.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1  burst request, per port.
- we0, we1  in  1  1 = write burst, 0 = read burst; sampled at grant.
- addr0, addr1  in  ADDR_W  burst start address; sampled at grant.
- len0, len1  in  LEN_W  beats minus 1; sampled at grant.
- wdata0, wdata1  in  DATA_W  write data for the current beat; used live in ISSUE.
- ack0, ack1  out  1  one-cycle pulse per completed beat.
- done0, done1  out  1  one-cycle pulse, coincident with the last ack of a burst.
- rdata0, rdata1  out  DATA_W  read data; valid while ack is high, held afterwards.
- busy  out  1  high when state is not IDLE.
- mem_write  out  1  to dataMemory memWrite.
- mem_read  out  1  to dataMemory memRead.
- mem_addr  out  ADDR_W  to dataMemory address.
- mem_data  out  DATA_W  to dataMemory data.
- mem_out  in  DATA_W  from dataMemory out (combinational read).

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rr_last=1, so port 0 wins the first tie.
  - All ack/done/busy/mem_write/mem_read = 0.
  - mem_addr=0, rdata0/1=0, beat counter=0, grant=0.
  - A reset mid-burst aborts it: no done, no further writes. mem_write must be 0 combinationally while reset_n=0.
- FSM states: IDLE, ISSUE, ACK.
- IDLE:
  - If only reqN is set, grant N.
  - If both are set, grant the port != rr_last.
  - On grant: latch we, addr, len of the winner into cur_we, cur_addr, cnt. Next state is ISSUE.
  - If no request, stay in IDLE.
- ISSUE (one cycle):
  - mem_addr=cur_addr, mem_write=cur_we, mem_read=!cur_we.
  - mem_data = wdata of the granted port.
  - At the closing posedge the write commits in memory, and rdata_grant <= mem_out when reading (rdata of the other port is unchanged).
  - ack_grant is set for the next cycle. Next state is ACK.
- ACK (one cycle):
  - ack_grant=1, mem_write=0, mem_read=0.
  - If cnt==0: done_grant=1, rr_last=grant, next state IDLE.
  - Otherwise: cnt-1, cur_addr+1 (8-bit wrap, 255->0), next state ISSUE.
- Throughput:
  - 2 cycles per beat.
  - Grant-to-first-ack = 2 cycles after the request is seen in IDLE.
  - Burst of n beats: req seen at cycle t, done at t+2n.
- Write-data handshake: the requester presents beat k+1 data when it sees ack for beat k.
- Request handling:
  - Requests are sampled only in IDLE. Deasserting req mid-burst is ignored; the burst runs to completion.
  - A request held after done is re-arbitrated in the next IDLE cycle. If the other port is requesting, it wins.
- Outputs and combinational paths:
  - mem_write, mem_read, mem_addr, ack and done are decoded from registers only. There is no combinational path from req to mem_* controls.
  - mem_data is a mux of wdata0/wdata1 selected by the registered grant.
- Simultaneous requests arriving in the same cycle are arbitrated purely by rr_last.

Decomposition:
- Package data_mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, ACK);
  - the ADDR_W/DATA_W/LEN_W defaults;
  - the port index constants PORT_CPU=0, PORT_DMA=1.
- One sub-module: mem_rr_pick2 (2-way round-robin pick from req0, req1, rr_last → gnt_valid, gnt_idx; combinational).
- The FSM, counters and muxing stay in the top module.

Test Plan:
- Single read: with preload word[100]=10, req1=1, we1=0, addr1=100, len1=0 → mem_read high 1 cycle with mem_addr=100; ack1 and done1 pulse together; rdata1=10.
- Burst read with wrap: req0, addr0=254, len0=2 → mem_addr sequence 254, 255, 0. Three ack0 pulses 2 cycles apart; done0 only on the third.
- Write burst then readback:
  - Write: req1, we1=1, addr1=110, len1=1, wdata 8'hA5 then 8'h3C (changed on ack) → mem_write pulses twice.
  - Readback: a port-0 read of 110, len 1 → rdata0 = A5, then 3C.
- Contention and fairness: req0 and req1 held high from reset release with len=0 → grants alternate 0,1,0,1. No ack overlap; busy stays high through the alternation except the IDLE cycle between bursts.
- Mid-burst req drop and async reset:
  - Drop: req0 dropped after the first ack of a len=3 burst → all 4 beats complete.
  - Reset: reset_n pulsed low during ISSUE of a write → mem_write falls immediately, the memory word is unchanged, state returns to IDLE, and no done is asserted.
